// File: rtl/ex_bneck_wmem_ctrl_if.sv
// ex_bneck_wmem_ctrl_if
// Bundles every signal between the bneck expansion weight-memory sequencer
// and its surroundings: EX layer commands, the load stream handshake, the
// weight stream to the PE array, status, and the shared memory controls.
//   slave  : the sequencer (drives ld_ready, w_valid/w_last, status, mem_*)
//   master : the layer controller / stream / PE side (drives commands,
//            ld_valid, w_ready)
interface ex_bneck_wmem_ctrl_if #(
    parameter int IDX_W = 10
);
    logic             load_start;
    logic [IDX_W-1:0] load_base;
    logic [IDX_W-1:0] load_count;
    logic             ld_valid;
    logic             ld_ready;
    logic             fetch_start;
    logic [IDX_W-1:0] fetch_base;
    logic [IDX_W-1:0] fetch_count;
    logic             w_valid;
    logic             w_ready;
    logic             w_last;
    logic             busy;
    logic             done;
    logic             cmd_err;
    logic [IDX_W-1:0] mem_index;
    logic             mem_en;
    logic             mem_rd;
    logic             mem_wr;

    modport slave (
        input  load_start, load_base, load_count, ld_valid,
        input  fetch_start, fetch_base, fetch_count, w_ready,
        output ld_ready, w_valid, w_last, busy, done, cmd_err,
        output mem_index, mem_en, mem_rd, mem_wr
    );

    modport master (
        output load_start, load_base, load_count, ld_valid,
        output fetch_start, fetch_base, fetch_count, w_ready,
        input  ld_ready, w_valid, w_last, busy, done, cmd_err,
        input  mem_index, mem_en, mem_rd, mem_wr
    );
endinterface

// File: rtl/ex_bneck_wmem_ctrl.sv
// ex_bneck_wmem_ctrl
// Sequencer for the bneck 1x1 expansion weight memory. All 256 memory
// segments share one row index, so this block owns index/en/rd/wr and runs
// two commands: LOAD (write rows from a valid/ready stream) and FETCH
// (stream rows to the PE array under valid/ready backpressure). Data buses
// bypass this block entirely.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - ex_bneck_wmem_ctrl_if.slave: commands, ld_valid/ld_ready,
//          w_valid/w_ready/w_last, busy/done/cmd_err, mem_index/en/rd/wr
module ex_bneck_wmem_ctrl #(
    parameter int HEIGHT = 657,
    parameter int IDX_W  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    ex_bneck_wmem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FETCH} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] rem;
    logic             w_valid_q;
    logic             w_last_q;
    logic             done_q;
    logic             cmd_err_q;

    logic             load_ok;
    logic             fetch_ok;
    logic             ld_ready_c;
    logic             wr_c;
    logic             issue;
    logic             last_load;
    logic             last_fetch;

    // Range check: sum is one bit wider so base+count cannot wrap past HEIGHT.
    function automatic logic cmd_ok(input logic [IDX_W-1:0] base,
                                    input logic [IDX_W-1:0] count);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + {1'b0, count};
        return (count != '0) && (sum <= (IDX_W+1)'(HEIGHT));
    endfunction

    assign load_ok  = cmd_ok(bus.load_base, bus.load_count);
    assign fetch_ok = cmd_ok(bus.fetch_base, bus.fetch_count);

    assign last_load  = (state == S_LOAD) && bus.ld_valid && (rem == IDX_W'(1));
    assign last_fetch = (state == S_FETCH) && w_valid_q && bus.w_ready && w_last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                // load_start has priority; a simultaneous fetch_start is dropped.
                if (bus.load_start) begin
                    if (load_ok) state_nxt = S_LOAD;
                end else if (bus.fetch_start && fetch_ok) begin
                    state_nxt = S_FETCH;
                end
            end
            S_LOAD:  if (last_load)  state_nxt = S_IDLE;
            S_FETCH: if (last_fetch) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ld_ready_c = (state == S_LOAD);
        wr_c       = (state == S_LOAD) && bus.ld_valid;
        // A new read may go out only if the output slot is empty or draining now.
        issue      = (state == S_FETCH) && (rem != '0) && (!w_valid_q || bus.w_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            rem       <= '0;
            w_valid_q <= 1'b0;
            w_last_q  <= 1'b0;
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            done_q    <= last_load || last_fetch;
            cmd_err_q <= (state == S_IDLE) &&
                         (bus.load_start ? !load_ok : (bus.fetch_start && !fetch_ok));

            if (state == S_IDLE) begin
                if (bus.load_start) begin
                    if (load_ok) begin
                        ptr <= bus.load_base;
                        rem <= bus.load_count;
                    end
                end else if (bus.fetch_start && fetch_ok) begin
                    ptr <= bus.fetch_base;
                    rem <= bus.fetch_count;
                end
            end else if (wr_c || issue) begin
                ptr <= ptr + IDX_W'(1);
                rem <= rem - IDX_W'(1);
            end

            // Memory data_out is valid the cycle after a read and holds while
            // mem_rd is low, so w_valid simply tracks issue vs. acceptance.
            if (issue) begin
                w_valid_q <= 1'b1;
                w_last_q  <= (rem == IDX_W'(1));
            end else if (bus.w_ready) begin
                w_valid_q <= 1'b0;
                w_last_q  <= 1'b0;
            end
        end
    end

    assign bus.ld_ready  = ld_ready_c;
    assign bus.w_valid   = w_valid_q;
    assign bus.w_last    = w_last_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_q;
    assign bus.cmd_err   = cmd_err_q;
    assign bus.mem_index = ptr;
    assign bus.mem_en    = wr_c || issue;
    assign bus.mem_rd    = issue;
    assign bus.mem_wr    = wr_c;

endmodule

// File: tb/tb_ex_bneck_wmem_ctrl.sv
// tb_ex_bneck_wmem_ctrl
// Directed bench for ex_bneck_wmem_ctrl with a behavioural weight memory
// (1-cycle read latency, data_out held while mem_rd is low).
module tb_ex_bneck_wmem_ctrl;

    localparam int HEIGHT = 657;
    localparam int IDX_W  = 10;

    logic        clk;
    logic        rst;
    logic        fill;
    logic [15:0] ld_data;
    logic [15:0] data_out;
    logic [15:0] mem [0:HEIGHT-1];
    logic [8:0]  flags;
    int          total;
    int          bad;

    ex_bneck_wmem_ctrl_if #(.IDX_W(IDX_W)) bus ();

    ex_bneck_wmem_ctrl #(.HEIGHT(HEIGHT), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign flags = {bus.ld_ready, bus.w_valid, bus.w_last, bus.busy, bus.done,
                    bus.cmd_err, bus.mem_en, bus.mem_rd, bus.mem_wr};

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < HEIGHT; i++) mem[i] <= 16'h5000 + 16'(i);
        end else begin
            if (bus.mem_en && bus.mem_wr) mem[bus.mem_index] <= ld_data;
            if (bus.mem_en && bus.mem_rd) data_out <= mem[bus.mem_index];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        bus.load_start  = 1'b0;
        bus.load_base   = '0;
        bus.load_count  = '0;
        bus.ld_valid    = 1'b0;
        bus.fetch_start = 1'b0;
        bus.fetch_base  = '0;
        bus.fetch_count = '0;
        bus.w_ready     = 1'b0;
        ld_data         = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fill = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        total++; if (flags !== 9'b0) begin bad++; $display("FAIL reset_flags got=%b exp=000000000", flags); end
        total++; if (bus.mem_index !== 10'd0) begin bad++; $display("FAIL reset_index got=%0d exp=0", bus.mem_index); end
        fill = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        bus.load_base = 10'd0; bus.load_count = 10'd4; bus.load_start = 1'b1;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0 || bus.mem_en !== 1'b0) begin bad++; $display("FAIL load_pre busy=%b mem_en=%b exp=0,0", bus.busy, bus.mem_en); end
        @(posedge clk); #1;
        bus.load_start = 1'b0; bus.ld_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_data = 16'h0100 + 16'(i);
            @(negedge clk);
            total++; if ({bus.ld_ready, bus.mem_wr, bus.mem_en, bus.mem_rd, bus.done} !== 5'b11100) begin bad++; $display("FAIL load_beat%0d rdy/wr/en/rd/done got=%b exp=11100", i, {bus.ld_ready, bus.mem_wr, bus.mem_en, bus.mem_rd, bus.done}); end
            total++; if (bus.mem_index !== 10'(i)) begin bad++; $display("FAIL load_index%0d got=%0d exp=%0d", i, bus.mem_index, i); end
            @(posedge clk); #1;
        end
        bus.ld_valid = 1'b0;
        @(negedge clk);
        total++; if ({bus.done, bus.busy, bus.ld_ready} !== 3'b100) begin bad++; $display("FAIL load_done done/busy/rdy got=%b exp=100", {bus.done, bus.busy, bus.ld_ready}); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL load_done_pulse got=%b exp=0", bus.done); end
        for (int i = 0; i < 4; i++) begin
            total++; if (mem[i] !== 16'h0100 + 16'(i)) begin bad++; $display("FAIL load_mem%0d got=%h exp=%h", i, mem[i], 16'h0100 + 16'(i)); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fetch_b2b();
        bit er [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        int ei [4] = '{10, 11, 12, 0};
        bit ev [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        bit el [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int ed [4] = '{0, 10, 11, 12};
        bus.fetch_base = 10'd10; bus.fetch_count = 10'd3; bus.fetch_start = 1'b1; bus.w_ready = 1'b1;
        @(posedge clk); #1;
        bus.fetch_start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if ({bus.mem_rd, bus.w_valid, bus.w_last} !== {er[c], ev[c], el[c]}) begin bad++; $display("FAIL b2b_c%0d rd/wv/wl got=%b exp=%b", c, {bus.mem_rd, bus.w_valid, bus.w_last}, {er[c], ev[c], el[c]}); end
            if (er[c]) begin
                total++; if (bus.mem_index !== 10'(ei[c])) begin bad++; $display("FAIL b2b_index_c%0d got=%0d exp=%0d", c, bus.mem_index, ei[c]); end
            end
            if (ev[c]) begin
                total++; if (data_out !== 16'h5000 + 16'(ed[c])) begin bad++; $display("FAIL b2b_data_c%0d got=%h exp=%h", c, data_out, 16'h5000 + 16'(ed[c])); end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++; if ({bus.done, bus.busy, bus.w_valid} !== 3'b100) begin bad++; $display("FAIL b2b_done done/busy/wv got=%b exp=100", {bus.done, bus.busy, bus.w_valid}); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_done_pulse got=%b exp=0", bus.done); end
        @(posedge clk); #1;
        bus.w_ready = 1'b0;
    endtask

    task automatic test_fetch_stall();
        bit pat [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] got [$];
        bus.fetch_base = 10'd0; bus.fetch_count = 10'd4; bus.fetch_start = 1'b1;
        @(posedge clk); #1;
        bus.fetch_start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            bus.w_ready = pat[c];
            @(negedge clk);
            if (bus.w_valid && bus.w_ready) got.push_back(data_out);
            if (!pat[c]) begin
                total++; if ({bus.mem_rd, bus.mem_en, bus.w_valid} !== 3'b001) begin bad++; $display("FAIL stall_c%0d rd/en/wv got=%b exp=001", c, {bus.mem_rd, bus.mem_en, bus.w_valid}); end
                total++; if (data_out !== 16'h0101) begin bad++; $display("FAIL stall_data_c%0d got=%h exp=0101", c, data_out); end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b exp=1", bus.done); end
        total++; if (got.size() !== 4) begin bad++; $display("FAIL stall_rows got=%0d exp=4", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            total++; if (got[i] !== 16'h0100 + 16'(i)) begin bad++; $display("FAIL stall_row%0d got=%h exp=%h", i, got[i], 16'h0100 + 16'(i)); end
        end
        @(posedge clk); #1;
        bus.w_ready = 1'b0;
    endtask

    task automatic test_reject();
        int nrd;
        int lastidx;
        bit seen;
        // FETCH 650+8 = 658 overruns the memory
        bus.fetch_base = 10'd650; bus.fetch_count = 10'd8; bus.fetch_start = 1'b1;
        @(negedge clk);
        total++; if ({bus.mem_en, bus.busy} !== 2'b00) begin bad++; $display("FAIL rej_fetch_pre en/busy got=%b exp=00", {bus.mem_en, bus.busy}); end
        @(posedge clk); #1;
        bus.fetch_start = 1'b0;
        @(negedge clk);
        total++; if ({bus.cmd_err, bus.busy, bus.mem_en, bus.done} !== 4'b1000) begin bad++; $display("FAIL rej_fetch err/busy/en/done got=%b exp=1000", {bus.cmd_err, bus.busy, bus.mem_en, bus.done}); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (bus.cmd_err !== 1'b0) begin bad++; $display("FAIL rej_fetch_pulse got=%b exp=0", bus.cmd_err); end
        @(posedge clk); #1;
        // LOAD with zero rows
        bus.load_base = 10'd5; bus.load_count = 10'd0; bus.load_start = 1'b1; bus.ld_valid = 1'b1;
        @(negedge clk);
        total++; if ({bus.mem_en, bus.busy} !== 2'b00) begin bad++; $display("FAIL rej_load_pre en/busy got=%b exp=00", {bus.mem_en, bus.busy}); end
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        @(negedge clk);
        total++; if ({bus.cmd_err, bus.busy, bus.mem_en, bus.ld_ready} !== 4'b1000) begin bad++; $display("FAIL rej_load err/busy/en/rdy got=%b exp=1000", {bus.cmd_err, bus.busy, bus.mem_en, bus.ld_ready}); end
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        // FETCH 649+8 = 657 fits exactly
        bus.fetch_base = 10'd649; bus.fetch_count = 10'd8; bus.fetch_start = 1'b1; bus.w_ready = 1'b1;
        @(posedge clk); #1;
        bus.fetch_start = 1'b0;
        nrd = 0; lastidx = -1; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (c == 0) begin
                total++; if ({bus.busy, bus.cmd_err} !== 2'b10) begin bad++; $display("FAIL acc_start busy/err got=%b exp=10", {bus.busy, bus.cmd_err}); end
            end
            if (bus.mem_rd) begin nrd++; lastidx = int'(bus.mem_index); end
            if (bus.done) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (!seen) begin bad++; $display("FAIL acc_done got=none exp=done within 20 cycles"); end
        total++; if (nrd !== 8) begin bad++; $display("FAIL acc_reads got=%0d exp=8", nrd); end
        total++; if (lastidx !== 656) begin bad++; $display("FAIL acc_lastidx got=%0d exp=656", lastidx); end
        bus.w_ready = 1'b0;
    endtask

    task automatic test_load_priority();
        int nwr = 0, nrd = 0, ndone = 0, lastidx = -1;
        bus.load_base = 10'd20; bus.load_count = 10'd3; bus.load_start = 1'b1;
        bus.fetch_base = 10'd30; bus.fetch_count = 10'd2; bus.fetch_start = 1'b1;
        bus.w_ready = 1'b1;
        @(posedge clk); #1;
        bus.load_start = 1'b0; bus.fetch_start = 1'b0; bus.ld_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.fetch_start = (c == 1);
            ld_data = 16'h0200 + 16'(c);
            @(negedge clk);
            if (c == 0) begin
                total++; if ({bus.ld_ready, bus.mem_rd} !== 2'b10) begin bad++; $display("FAIL prio_state rdy/rd got=%b exp=10", {bus.ld_ready, bus.mem_rd}); end
            end
            if (bus.mem_wr) begin nwr++; lastidx = int'(bus.mem_index); end
            if (bus.mem_rd) nrd++;
            if (bus.done) ndone++;
            @(posedge clk); #1;
        end
        bus.ld_valid = 1'b0; bus.fetch_start = 1'b0; bus.w_ready = 1'b0;
        total++; if (nwr !== 3) begin bad++; $display("FAIL prio_writes got=%0d exp=3", nwr); end
        total++; if (nrd !== 0) begin bad++; $display("FAIL prio_reads got=%0d exp=0", nrd); end
        total++; if (ndone !== 1) begin bad++; $display("FAIL prio_dones got=%0d exp=1", ndone); end
        total++; if (lastidx !== 22) begin bad++; $display("FAIL prio_lastidx got=%0d exp=22", lastidx); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL prio_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        bus.fetch_base = 10'd0; bus.fetch_count = 10'd5; bus.fetch_start = 1'b1; bus.w_ready = 1'b1;
        @(posedge clk); #1;
        bus.fetch_start = 1'b0;
        repeat (2) begin @(negedge clk); @(posedge clk); #1; end
        @(negedge clk);
        total++; if ({bus.mem_rd, bus.w_valid} !== 2'b11 || bus.mem_index !== 10'd2) begin bad++; $display("FAIL rstmid_row2 rd/wv=%b idx=%0d exp=11,2", {bus.mem_rd, bus.w_valid}, bus.mem_index); end
        #1 rst = 1'b1;
        #1;
        total++; if (flags !== 9'b0) begin bad++; $display("FAIL rstmid_flags got=%b exp=000000000", flags); end
        total++; if (bus.mem_index !== 10'd0) begin bad++; $display("FAIL rstmid_index got=%0d exp=0", bus.mem_index); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        bus.fetch_base = 10'd0; bus.fetch_count = 10'd1; bus.fetch_start = 1'b1;
        @(posedge clk); #1;
        bus.fetch_start = 1'b0;
        @(negedge clk);
        total++; if ({bus.mem_rd, bus.w_valid} !== 2'b10 || bus.mem_index !== 10'd0) begin bad++; $display("FAIL after_rd rd/wv=%b idx=%0d exp=10,0", {bus.mem_rd, bus.w_valid}, bus.mem_index); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if ({bus.w_valid, bus.w_last, bus.mem_rd} !== 3'b110) begin bad++; $display("FAIL after_beat wv/wl/rd got=%b exp=110", {bus.w_valid, bus.w_last, bus.mem_rd}); end
        total++; if (data_out !== 16'h0100) begin bad++; $display("FAIL after_data got=%h exp=0100", data_out); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if ({bus.done, bus.busy, bus.w_valid} !== 3'b100) begin bad++; $display("FAIL after_done done/busy/wv got=%b exp=100", {bus.done, bus.busy, bus.w_valid}); end
        @(posedge clk); #1;
        bus.w_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_load();
        test_fetch_b2b();
        test_fetch_stall();
        test_reject();
        test_load_priority();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_bneck_wmem_ctrl.md
Name: ex_bneck_wmem_ctrl

Overview:
Sequencer for the bneck 1x1 expansion weight memory (256 parallel segments sharing one row index). Owns the shared index/en/rd/wr controls. Runs two command types:
- LOAD: writes a block of rows from a valid/ready stream.
- FETCH: streams a block of rows to the expansion PE array with valid/ready backpressure.
Sits between the EX layer controller (commands) and the weight memory; data buses connect directly between the stream, the memory and the PE array.

Parameters:
HEIGHT, 657, number of rows in the weight memory; legal indices are 0..HEIGHT-1
IDX_W, 10, width of the row index and count fields

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
load_start  input  1  LOAD command strobe; sampled in IDLE only
load_base  input  IDX_W  first row for LOAD
load_count  input  IDX_W  number of rows for LOAD
ld_valid  input  1  load stream beat valid; data goes straight to the memory data_in
ld_ready  output  1  controller accepts a load beat
fetch_start  input  1  FETCH command strobe; sampled in IDLE only
fetch_base  input  IDX_W  first row for FETCH
fetch_count  input  IDX_W  number of rows for FETCH
w_valid  output  1  memory data_out holds a valid weight row
w_ready  input  1  PE array consumes the row
w_last  output  1  qualifies w_valid for the final row of a FETCH
busy  output  1  state is not IDLE
done  output  1  one-cycle pulse when a command completes
cmd_err  output  1  one-cycle pulse when a command is rejected
mem_index  output  IDX_W  row index to the memory
mem_en  output  1  memory enable
mem_rd  output  1  memory read strobe
mem_wr  output  1  memory write strobe

Behaviour:
- Reset: all outputs are 0, the state is IDLE, and all pointers and counters are 0.
- States: IDLE, LOAD, FETCH.
- Memory contract: 1-cycle read latency. The memory's data_out holds its last read value while mem_rd=0.

IDLE
- If load_start=1 and fetch_start=1 in the same cycle, load_start wins and fetch_start is dropped.
- Command check: reject the command if count==0 or base+count>HEIGHT (sum computed IDX_W+1 bits wide).
- Rejected command: cmd_err=1 for one cycle; state stays IDLE.
- Accepted command: latch base into ptr and count into rem, then go to LOAD or FETCH.
- Start strobes are ignored in LOAD and FETCH.

LOAD
- ld_ready=1 for the whole state.
- mem_wr = mem_en = ld_valid, combinationally; mem_index = ptr.
- Each accepted beat: ptr+1, rem-1.
- When the beat with rem==1 is accepted: done=1 in the next cycle, state returns to IDLE, ld_ready falls.

FETCH
- issue = (rem!=0) & (!w_valid | w_ready).
- mem_rd = mem_en = issue, combinationally; mem_index = ptr.
- On issue: ptr+1, rem-1.
- w_valid register:
  - set to 1 on the cycle after an issue;
  - held at 1 while w_ready=0;
  - cleared on acceptance when no new issue occurs in that cycle.
- Back-to-back operation: with w_ready held at 1, the block issues one row per cycle and w_valid stays high continuously.
- w_last is registered alongside w_valid; it is 1 for the row issued while rem==1.
- Completion: when the w_last beat is accepted, done=1 in the next cycle and state returns to IDLE.

Other rules
- mem_index is ptr in every state; in IDLE its value is don't-care with mem_en=0.
- ptr never wraps, because commands are range-checked on entry.
- Reset mid-command aborts immediately: all outputs go to 0 and state goes to IDLE. Partially written rows keep their contents.
- done and cmd_err never assert in the same cycle.

Test Plan:
1. LOAD base=0 count=4 with ld_valid held at 1 → mem_wr high for 4 cycles at indices 0,1,2,3; done pulses one cycle later; busy=0 afterwards.
2. FETCH base=10 count=3 with w_ready=1 → mem_rd at indices 10,11,12 on consecutive cycles; w_valid high for 3 cycles starting one cycle later; w_last on the 3rd; done pulses once.
3. FETCH base=0 count=4 with w_ready low for 2 cycles during row 1 → w_valid and data_out stay stable, no mem_rd while stalled; the rows delivered are exactly 0,1,2,3 with no duplicates.
4. Rejected commands → cmd_err pulses, busy stays 0, no mem_en:
   - FETCH base=650 count=8 (658>657);
   - LOAD count=0.
   FETCH base=649 count=8 is accepted.
5. Same-cycle load_start and fetch_start → LOAD executes. A fetch_start issued mid-LOAD is ignored: no extra mem_rd, exactly one done.
6. rst asserted during row 2 of a count=5 FETCH → all outputs 0 asynchronously. A following FETCH base=0 count=1 completes normally.
